instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the memory controller and the instruction fetcher. It accepts the fetcher's level-held fetch request (`IFIC_en`/`IFIC_pc`) and returns one 32-bit instruction per response pulse on `ICIF_en`/`ICIF_data`. On a miss it refills a whole line from the memory controller one word at a time. It holds the last delivered instruction stable, because the fetcher keeps decoding `ICIF_data` while it waits on the predictor.

---
 rtl/instruction_cache.sv | 121 ++++++++++++
 tb/tb_instruction_cache.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache.
//   Sys_clk / Sys_rst / Sys_rdy : clock, async active-high reset, global enable.
//   IFIC_en / IFIC_pc           : level-held fetch request and address.
//   ICIF_en / ICIF_data         : one-cycle response pulse, held instruction word.
//   ICMC_en / ICMC_addr         : level-held word read request to memory.
//   MCIC_en / MCIC_data         : memory read-data valid pulse and word.
module instruction_cache #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned INDEX_WIDTH  = 6,
   parameter int unsigned OFFSET_WIDTH = 4
) (
   input  logic                  Sys_clk,
   input  logic                  Sys_rst,
   input  logic                  Sys_rdy,
   input  logic                  IFIC_en,
   input  logic [ADDR_WIDTH-1:0] IFIC_pc,
   output logic                  ICIF_en,
   output logic [31:0]           ICIF_data,
   output logic                  ICMC_en,
   output logic [ADDR_WIDTH-1:0] ICMC_addr,
   input  logic                  MCIC_en,
   input  logic [31:0]           MCIC_data
);

   localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int unsigned WORD_WIDTH = OFFSET_WIDTH - 2;
   localparam int unsigned LINES      = 1 << INDEX_WIDTH;
   localparam int unsigned WORDS      = 1 << WORD_WIDTH;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                          state;
   logic [LINES-1:0]                valid;
   logic [TAG_WIDTH-1:0]            tags [LINES];
   logic [31:0]                     data [LINES*WORDS];
   logic [TAG_WIDTH+INDEX_WIDTH-1:0] miss_line;
   logic [WORD_WIDTH-1:0]           cnt;
   logic                            cooldown;

   logic [TAG_WIDTH-1:0]   pc_tag;
   logic [INDEX_WIDTH-1:0] pc_idx;
   logic [WORD_WIDTH-1:0]  pc_word;
   logic [TAG_WIDTH-1:0]   miss_tag;
   logic [INDEX_WIDTH-1:0] miss_idx;
   logic                   hit;
   logic                   last_word;
   logic                   fill;
   logic                   unused_pc;

   assign pc_tag    = IFIC_pc[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];
   assign pc_idx    = IFIC_pc[OFFSET_WIDTH +: INDEX_WIDTH];
   assign pc_word   = IFIC_pc[2 +: WORD_WIDTH];
   assign unused_pc = ^IFIC_pc[1:0];
   assign miss_tag  = miss_line[INDEX_WIDTH +: TAG_WIDTH];
   assign miss_idx  = miss_line[INDEX_WIDTH-1:0];
   assign hit       = valid[pc_idx] && (tags[pc_idx] == pc_tag);
   assign last_word = (cnt == '1);
   assign fill      = Sys_rdy && (state == REFILL) && MCIC_en;

   // Control, valid bits and registered outputs.
   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         state     <= IDLE;
         valid     <= '0;
         miss_line <= '0;
         cnt       <= '0;
         cooldown  <= 1'b0;
         ICIF_en   <= 1'b0;
         ICIF_data <= '0;
         ICMC_en   <= 1'b0;
         ICMC_addr <= '0;
      end else if (Sys_rdy) begin
         ICIF_en  <= 1'b0;
         // One dead cycle after every response: the fetcher changes the pc on
         // the same edge it takes the response, so the old pc must not re-hit.
         cooldown <= 1'b0;
         case (state)
            IDLE: begin
               if (IFIC_en && !cooldown) begin
                  if (hit) begin
                     ICIF_en   <= 1'b1;
                     ICIF_data <= data[{pc_idx, pc_word}];
                     cooldown  <= 1'b1;
                  end else begin
                     valid[pc_idx] <= 1'b0;
                     miss_line     <= {pc_tag, pc_idx};
                     cnt           <= '0;
                     ICMC_en       <= 1'b1;
                     ICMC_addr     <= {pc_tag, pc_idx, {OFFSET_WIDTH{1'b0}}};
                     state         <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (MCIC_en) begin
                  if (last_word) begin
                     valid[miss_idx] <= 1'b1;
                     ICMC_en         <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     cnt       <= cnt + WORD_WIDTH'(1);
                     ICMC_addr <= ICMC_addr + ADDR_WIDTH'(4);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data and tag storage: no reset, validity is carried by the valid bits.
   always_ff @(posedge Sys_clk) begin
      if (fill) begin
         data[{miss_idx, cnt}] <= MCIC_data;
         if (last_word) begin
            tags[miss_idx] <= miss_tag;
         end
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: self-checking bench for instruction_cache.
// A line-granular behavioural model predicts every output each cycle; directed
// scenarios pin the model with literal values, then a randomized phase runs.
`timescale 1ns/1ps
module tb_instruction_cache;

   logic        Sys_clk = 1'b0;
   logic        Sys_rst = 1'b0;
   logic        Sys_rdy = 1'b0;
   logic        IFIC_en = 1'b0;
   logic [31:0] IFIC_pc = '0;
   logic        MCIC_en = 1'b0;
   logic [31:0] MCIC_data = '0;
   logic        ICIF_en;
   logic [31:0] ICIF_data;
   logic        ICMC_en;
   logic [31:0] ICMC_addr;

   instruction_cache #(
      .ADDR_WIDTH  (32),
      .INDEX_WIDTH (6),
      .OFFSET_WIDTH(4)
   ) dut (
      .Sys_clk  (Sys_clk),
      .Sys_rst  (Sys_rst),
      .Sys_rdy  (Sys_rdy),
      .IFIC_en  (IFIC_en),
      .IFIC_pc  (IFIC_pc),
      .ICIF_en  (ICIF_en),
      .ICIF_data(ICIF_data),
      .ICMC_en  (ICMC_en),
      .ICMC_addr(ICMC_addr),
      .MCIC_en  (MCIC_en),
      .MCIC_data(MCIC_data)
   );

   always #5 Sys_clk = ~Sys_clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Backing memory contents: first line is the literal pattern 0x11..0x44.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'h10) return 32'h11 * ((a >> 2) + 32'd1);
      return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
   endfunction

   // ---------------- behavioural model (line numbers, plain arithmetic) ----
   bit          m_valid [64];
   int unsigned m_tag   [64];
   logic [31:0] m_data  [64][4];
   bit          m_busy;
   bit          m_cool;
   int unsigned m_line;
   int unsigned m_got;
   logic        m_ic_en;
   logic        m_mc_en;
   logic [31:0] m_ic_data;
   logic [31:0] m_mc_addr;
   logic [31:0] m_resp_addr;

   function void model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy = 0; m_cool = 0; m_got = 0; m_line = 0;
      m_ic_en = 1'b0; m_ic_data = '0; m_mc_en = 1'b0; m_mc_addr = '0; m_resp_addr = '0;
   endfunction

   always @(posedge Sys_clk) begin : model
      int unsigned line;
      int unsigned idx;
      bit          respond;
      if (!Sys_rst && Sys_rdy) begin
         respond = 0;
         line    = IFIC_pc >> 4;
         idx     = line % 64;
         if (!m_busy) begin
            if (IFIC_en && !m_cool) begin
               if (m_valid[idx] && m_tag[idx] == line / 64) begin
                  respond     = 1;
                  m_ic_data   = m_data[idx][IFIC_pc[3:2]];
                  m_resp_addr = {IFIC_pc[31:2], 2'b00};
               end else begin
                  m_valid[idx] = 0;
                  m_busy       = 1;
                  m_line       = line;
                  m_got        = 0;
                  m_mc_en      = 1'b1;
                  m_mc_addr    = line * 16;
               end
            end
         end else if (MCIC_en) begin
            m_data[m_line % 64][m_got] = MCIC_data;
            m_got++;
            if (m_got == 4) begin
               m_valid[m_line % 64] = 1;
               m_tag[m_line % 64]   = m_line / 64;
               m_mc_en              = 1'b0;
               m_busy               = 0;
            end else begin
               m_mc_addr = m_line * 16 + m_got * 4;
            end
         end
         m_ic_en = respond;
         m_cool  = respond;
      end
   end

   // ---------------- per-cycle compare and memory-return monitor ----------
   bit          checking = 0;
   int unsigned cyc = 0;
   logic [31:0] addr_q[$];
   int unsigned ret_cyc[$];

   always @(negedge Sys_clk) begin
      if (checking) begin
         check("ICIF_en", {31'd0, ICIF_en}, {31'd0, m_ic_en});
         check("ICIF_data", ICIF_data, m_ic_data);
         check("ICMC_en", {31'd0, ICMC_en}, {31'd0, m_mc_en});
         check("ICMC_addr", ICMC_addr, m_mc_addr);
         if (m_ic_en) check("resp_vs_mem", ICIF_data, mem_word(m_resp_addr));
         if (MCIC_en && Sys_rdy && ICMC_en) begin
            addr_q.push_back(ICMC_addr);
            ret_cyc.push_back(cyc);
         end
      end
      cyc++;
   end

   // ---------------- stimulus helpers --------------------------------------
   int unsigned mem_rate   = 100;
   bit          stall_gate = 1;

   task automatic tick();
      @(posedge Sys_clk);
      #1;
      if (ICMC_en && (Sys_rdy || !stall_gate) && $urandom_range(99) < mem_rate) begin
         MCIC_en   = 1'b1;
         MCIC_data = mem_word(ICMC_addr);
      end else begin
         MCIC_en   = 1'b0;
         MCIC_data = $urandom;
      end
   endtask

   task automatic wait_resp(input string name);
      int unsigned n = 0;
      do begin
         tick();
         n++;
      end while (!ICIF_en && n < 60);
      check({name, "_timeout"}, {31'd0, ICIF_en}, 32'd1);
   endtask

   task automatic wait_words(input string name, input int unsigned k);
      int unsigned n = 0;
      do begin
         tick();
         n++;
      end while (addr_q.size() < k && n < 60);
      check({name, "_timeout"}, addr_q.size(), k);
   endtask

   function automatic logic [31:0] rand_pc();
      int unsigned idx_sel [4] = '{0, 1, 16, 63};
      logic [31:0] t, i, w;
      t = $urandom_range(2);
      i = idx_sel[$urandom_range(3)];
      w = $urandom_range(3);
      return (t << 10) | (i << 4) | (w << 2) | $urandom_range(3);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      #1;
      Sys_rst = 1'b1;
      model_reset();
      #1;
      check("rst_ICIF_en", {31'd0, ICIF_en}, 32'd0);
      check("rst_ICIF_data", ICIF_data, 32'd0);
      check("rst_ICMC_en", {31'd0, ICMC_en}, 32'd0);
      check("rst_ICMC_addr", ICMC_addr, 32'd0);
      checking = 1;
      tick();
      tick();
      Sys_rst = 1'b0;
      Sys_rdy = 1'b1;

      // Cold miss at 0x0.
      IFIC_en = 1'b1;
      IFIC_pc = 32'h0;
      wait_resp("cold");
      check("cold_data", ICIF_data, 32'h11);
      check("cold_words", addr_q.size(), 32'd4);
      if (addr_q.size() == 4) begin
         for (int i = 0; i < 4; i++) check("cold_addr", addr_q[i], 32'(4 * i));
         check("cold_latency", cyc - ret_cyc[3], 32'd2);
      end

      // Sequential hits; pc=0x4 held one extra cycle must not re-respond.
      IFIC_pc = 32'h4;
      wait_resp("seq4");
      check("seq4_data", ICIF_data, 32'h22);
      tick();
      check("seq4_nodup", {31'd0, ICIF_en}, 32'd0);
      IFIC_pc = 32'h8;
      wait_resp("seq8");
      check("seq8_data", ICIF_data, 32'h33);
      check("seq_no_refill", addr_q.size(), 32'd4);

      // Hold for predictor.
      IFIC_en = 1'b0;
      repeat (5) begin
         tick();
         check("hold_data", ICIF_data, 32'h33);
         check("hold_en", {31'd0, ICIF_en}, 32'd0);
      end

      // Conflict eviction at the same index.
      base    = addr_q.size();
      IFIC_en = 1'b1;
      IFIC_pc = 32'h400;
      wait_resp("conf");
      check("conf_data", ICIF_data, mem_word(32'h400));
      check("conf_words", addr_q.size(), base + 4);
      if (addr_q.size() == base + 4)
         for (int i = 0; i < 4; i++) check("conf_addr", addr_q[base+i], 32'h400 + 32'(4 * i));
      base    = addr_q.size();
      IFIC_pc = 32'h0;
      wait_resp("evict");
      check("evict_data", ICIF_data, 32'h11);
      check("evict_words", addr_q.size(), base + 4);
      if (addr_q.size() > base) check("evict_addr", addr_q[base], 32'h0);

      // Redirect mid-refill.
      base    = addr_q.size();
      IFIC_pc = 32'h100;
      wait_words("redir", base + 2);
      IFIC_pc = 32'h4;
      wait_resp("redir");
      check("redir_data", ICIF_data, 32'h22);
      check("redir_words", addr_q.size(), base + 4);
      if (addr_q.size() == base + 4) check("redir_last", addr_q[base+3], 32'h10C);

      // Reset in the middle of a refill.
      base    = addr_q.size();
      IFIC_pc = 32'h200;
      wait_words("rstmid", base + 2);
      Sys_rst = 1'b1;
      MCIC_en = 1'b0;
      model_reset();
      #1;
      check("rstmid_ICMC_en", {31'd0, ICMC_en}, 32'd0);
      tick();
      tick();
      Sys_rst = 1'b0;
      base    = addr_q.size();
      wait_resp("rstmid_refetch");
      check("rstmid_data", ICIF_data, mem_word(32'h200));
      if (addr_q.size() > base) check("rstmid_remiss", addr_q[base], 32'h200);
      else check("rstmid_remiss_words", addr_q.size(), base + 1);

      // Sys_rdy low for 3 cycles mid-refill.
      base    = addr_q.size();
      IFIC_pc = 32'h300;
      wait_words("stall", base + 2);
      Sys_rdy = 1'b0;
      MCIC_en = 1'b0;
      repeat (3) begin
         tick();
         check("stall_addr", ICMC_addr, 32'h308);
         check("stall_en", {31'd0, ICMC_en}, 32'd1);
      end
      Sys_rdy = 1'b1;
      wait_resp("stall");
      check("stall_data", ICIF_data, mem_word(32'h300));
      check("stall_words", addr_q.size(), base + 4);
      if (addr_q.size() == base + 4) check("stall_last", addr_q[base+3], 32'h30C);

      // Randomized phase against the model.
      stall_gate = 0;
      mem_rate   = 60;
      repeat (3000) begin
         tick();
         if ($urandom_range(999) < 3) begin
            Sys_rst = 1'b1;
            MCIC_en = 1'b0;
            model_reset();
            tick();
            Sys_rst = 1'b0;
         end
         Sys_rdy = ($urandom_range(9) != 0);
         IFIC_en = ($urandom_range(4) != 0);
         if (ICIF_en || $urandom_range(19) == 0) IFIC_pc = rand_pc();
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
